monster_lane_engine: RTL and testbench
======================================

// Module: monster_lane_engine
// PURPOSE
//  Parametrised monster spawn/advance/strike engine for the four-lane arena game.
//  Replaces the fixed 12-monster, 3-step, two-clock state machine.
//  Single-clock with a move_tick enable, LFSR spawning, a RUN/OVER FSM, and a saturating score.
//  Sits between the hero/input logic and the sprite renderer, which decodes state_monsters.
// PARAMETERS
//  MONSTERS      12       monster slots (1..32)
//  STEPS         3        positions per lane; step STEPS-1 is the strike position (2..16)
//  SPAWN_THRESH  4        spawn when lfsr[3:0] < SPAWN_THRESH (0 = never spawn, 16 = always spawn)
//  LFSR_SEED     16'hACE1 LFSR reset value; must be non-zero
//  SW = $clog2(STEPS) (localparam); REC = 3+SW bits per monster
// PORTS
//  clk_game        in   1             system clock; all logic is posedge
//  rst_n           in   1             asynchronous, active-low reset
//  toggle          in   1             run request level (power toggle)
//  move_tick       in   1             one-cycle advance strobe
//  pressing        in   1             attack button level
//  state_hero      in   2             hero facing: 0=down 1=up 2=right 3=left
//  start           out  1             1 while in RUN
//  game_over       out  1             1 while in OVER
//  kill_pulse      out  1             one-cycle pulse on the tick that killed a monster
//  score           out  16            kill count; saturates at 16'hFFFF
//  state_monsters  out  MONSTERS*REC  record i = {step[SW-1:0], lane[1:0], alive}; LSB = alive
// BEHAVIOUR
//  Reset: FSM=IDLE; start, game_over, kill_pulse, score, state_monsters, attack latch all 0; lfsr=LFSR_SEED.
//  LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Advances every clk_game cycle in every state.
//  Lane: 0=up 1=down 2=left 3=right. A strike is successful only if hero facing == lane^1.
//  FSM:
//   - IDLE: all records are held at 0. When toggle=1: enter RUN next cycle, clear score, assert start.
//   - RUN: if toggle=0, go to IDLE and clear all records (this takes priority over move_tick in the same cycle).
//   - OVER: records and score are frozen for display. When toggle=0, go to IDLE.
//  Attack latch: set on a rising edge of pressing (pressing registered one cycle), capturing state_hero.
//   - Later presses before the next tick overwrite the captured direction.
//   - Cleared on every move_tick processed in RUN.
//  On move_tick in RUN, all slots are evaluated from their pre-tick values:
//   - alive, step < STEPS-1: step+1.
//   - alive, step == STEPS-1, latch set and dir matches lane: alive=0, score+1 (saturating), kill_pulse=1.
//   - alive, step == STEPS-1, no matching attack: miss.
//   - At most one monster per lane can be at the strike step, so one attack kills at most one monster.
//   - Any miss on a tick: FSM->OVER next cycle, start=0, game_over=1. Kills on the same tick still count.
//     Post-tick records are still written.
//   - Spawn: at most one per tick, into the lowest-index slot that was dead pre-tick.
//     A slot freed by a kill on this tick is not reused until the next tick.
//     Condition: lfsr[3:0] < SPAWN_THRESH; new record = {step 0, lane lfsr[5:4], alive 1}.
//   - No free slot: spawn is skipped silently.
//  move_tick outside RUN: ignored. kill_pulse is 0 on every other cycle.
//  Outputs are registered; records update 1 cycle after the move_tick sample edge.
// CONFIGURATION
//  SPEEDUP_EN defined:
//   - Internal divider: monsters advance, strike and spawn only on every DIV-th move_tick.
//   - DIV resets to 4 on IDLE->RUN and decrements by 1 every 8 kills, floor 1.
//   - The attack latch clears only on effective ticks.
//  SPEEDUP_EN undefined: every move_tick is effective, and no divider logic is generated.
// TESTING
//  1 rst_n=0 with toggle=1 held -> all outputs 0; rst_n release -> start=1 after 1 clk, score=0, records 0.
//  2 SPAWN_THRESH=16, RUN, 1 tick -> slot0 alive, step0, lane=lfsr[5:4] per reference LFSR model; other slots 0.
//  3 Lane-0 monster at step 2, state_hero=1, press then tick -> slot dead, score=1, kill_pulse one cycle.
//  4 Lane-2 monster at step 2, state_hero=2 pressed -> game_over=1, start=0; records and score frozen on later ticks.
//  5 toggle=0 mid-RUN with move_tick in same cycle -> IDLE, records 0, no score change.
//    toggle=1 -> score cleared on restart.
//  6 MONSTERS=2, SPAWN_THRESH=16, STEPS=16 -> third tick spawns nothing; each slot killed frees it next tick.
//    Force score=16'hFFFF, kill -> stays 16'hFFFF.

Source files
------------

// File: rtl/monster_lane_engine.sv
// Four-lane monster engine: LFSR spawning, per-tick advance/strike, RUN/OVER FSM, saturating score.
// Optional build macro SPEEDUP_EN adds a move_tick divider that speeds up every 8 kills.
module monster_lane_engine #(
    parameter int unsigned MONSTERS     = 12,
    parameter int unsigned STEPS        = 3,
    parameter int unsigned SPAWN_THRESH = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    localparam int unsigned SW          = $clog2(STEPS),
    localparam int unsigned REC         = 3 + SW
) (
    input  logic                      clk_game,
    input  logic                      rst_n,
    input  logic                      toggle,
    input  logic                      move_tick,
    input  logic                      pressing,
    input  logic [1:0]                state_hero,
    output logic                      start,
    output logic                      game_over,
    output logic                      kill_pulse,
    output logic [15:0]               score,
    output logic [MONSTERS*REC-1:0]   state_monsters
);

    typedef enum logic [1:0] {StIdle, StRun, StOver} state_e;

    state_e              r_state;
    logic [15:0]         r_lfsr;
    logic [15:0]         r_score;
    logic                r_press_q;
    logic                r_latch;
    logic [1:0]          r_latch_dir;
    logic                r_start;
    logic                r_over;
    logic                r_kill;
    logic [MONSTERS-1:0] r_alive;
    logic [SW-1:0]       r_step [MONSTERS];
    logic [1:0]          r_lane [MONSTERS];

    logic [15:0]         w_lfsr_next;
    logic                w_press_edge;
    logic                w_spawn;
    logic                w_tick;
    logic                w_kill;
    logic                w_miss;
    logic                w_free;
    logic [MONSTERS-1:0] w_alive_d;
    logic [SW-1:0]       w_step_d [MONSTERS];
    logic [1:0]          w_lane_d [MONSTERS];

    assign w_lfsr_next  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_press_edge = pressing && !r_press_q;
    assign w_spawn      = 32'(r_lfsr[3:0]) < SPAWN_THRESH;

`ifdef SPEEDUP_EN
    logic [2:0] r_div;
    logic [2:0] r_div_cnt;
    logic [2:0] r_kill_cnt;

    // >= keeps the count sane when the divisor shrinks mid-count
    assign w_tick = move_tick && (r_div_cnt >= r_div - 3'd1);

    always_ff @(posedge clk_game or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= 3'd4;
            r_div_cnt  <= '0;
            r_kill_cnt <= '0;
        end else if (r_state == StIdle && toggle) begin
            r_div      <= 3'd4;
            r_div_cnt  <= '0;
            r_kill_cnt <= '0;
        end else if (r_state == StRun && toggle && move_tick) begin
            r_div_cnt <= w_tick ? 3'd0 : r_div_cnt + 3'd1;
            if (w_tick && w_kill) begin
                r_kill_cnt <= r_kill_cnt + 3'd1;
                if (r_kill_cnt == 3'd7 && r_div > 3'd1) r_div <= r_div - 3'd1;
            end
        end
    end
`else
    assign w_tick = move_tick;
`endif

    // Every slot is evaluated from its pre-tick value; spawn goes to the first slot dead pre-tick.
    always_comb begin
        w_alive_d = r_alive;
        w_step_d  = r_step;
        w_lane_d  = r_lane;
        w_kill    = 1'b0;
        w_miss    = 1'b0;
        w_free    = 1'b0;
        for (int i = 0; i < MONSTERS; i++) begin
            if (r_alive[i]) begin
                if (r_step[i] != SW'(STEPS - 1)) begin
                    w_step_d[i] = r_step[i] + 1'b1;
                end else if (r_latch && r_latch_dir == (r_lane[i] ^ 2'b01)) begin
                    w_alive_d[i] = 1'b0;
                    w_step_d[i]  = '0;
                    w_lane_d[i]  = '0;
                    w_kill       = 1'b1;
                end else begin
                    w_miss = 1'b1;
                end
            end else if (!w_free) begin
                w_free = 1'b1;
                if (w_spawn) begin
                    w_alive_d[i] = 1'b1;
                    w_step_d[i]  = '0;
                    w_lane_d[i]  = r_lfsr[5:4];
                end
            end
        end
    end

    always_ff @(posedge clk_game or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_lfsr      <= LFSR_SEED;
            r_score     <= '0;
            r_press_q   <= 1'b0;
            r_latch     <= 1'b0;
            r_latch_dir <= '0;
            r_start     <= 1'b0;
            r_over      <= 1'b0;
            r_kill      <= 1'b0;
            r_alive     <= '0;
            r_step      <= '{default: '0};
            r_lane      <= '{default: '0};
        end else begin
            r_lfsr    <= w_lfsr_next;
            r_press_q <= pressing;
            r_kill    <= 1'b0;
            if (w_press_edge) begin
                r_latch     <= 1'b1;
                r_latch_dir <= state_hero;
            end
            unique case (r_state)
                StIdle: begin
                    if (toggle) begin
                        r_state <= StRun;
                        r_start <= 1'b1;
                        r_score <= '0;
                    end
                end
                StRun: begin
                    if (!toggle) begin
                        r_state <= StIdle;
                        r_start <= 1'b0;
                        r_alive <= '0;
                        r_step  <= '{default: '0};
                        r_lane  <= '{default: '0};
                    end else if (w_tick) begin
                        if (!w_press_edge) r_latch <= 1'b0;
                        r_alive <= w_alive_d;
                        r_step  <= w_step_d;
                        r_lane  <= w_lane_d;
                        r_kill  <= w_kill;
                        if (w_kill && r_score != 16'hFFFF) r_score <= r_score + 16'd1;
                        if (w_miss) begin
                            r_state <= StOver;
                            r_start <= 1'b0;
                            r_over  <= 1'b1;
                        end
                    end
                end
                StOver: begin
                    if (!toggle) begin
                        r_state <= StIdle;
                        r_over  <= 1'b0;
                        r_alive <= '0;
                        r_step  <= '{default: '0};
                        r_lane  <= '{default: '0};
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign start      = r_start;
    assign game_over  = r_over;
    assign kill_pulse = r_kill;
    assign score      = r_score;

    always_comb begin
        state_monsters = '0;
        for (int i = 0; i < MONSTERS; i++) begin
            state_monsters[i*REC +: REC] = {r_step[i], r_lane[i], r_alive[i]};
        end
    end

endmodule

// File: tb/tb_monster_lane_engine.sv
// Bench for monster_lane_engine: two configurations driven against a behavioural game model.
module tb_monster_lane_engine;

    localparam int AM = 12;
    localparam int AS = 3;
    localparam int AR = 3 + $clog2(AS);
    localparam int BM = 2;
    localparam int BS = 16;
    localparam int BR = 3 + $clog2(BS);

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic a_toggle, a_tick, a_press, a_start, a_over, a_kill;
    logic [1:0]  a_hero;
    logic [15:0] a_score;
    logic [AM*AR-1:0] a_sm;
    logic b_toggle, b_tick, b_press, b_start, b_over, b_kill;
    logic [1:0]  b_hero;
    logic [15:0] b_score;
    logic [BM*BR-1:0] b_sm;

    monster_lane_engine #(.MONSTERS(AM), .STEPS(AS), .SPAWN_THRESH(16), .LFSR_SEED(16'hACE1)) dut_a (
        .clk_game(clk), .rst_n(rst_n), .toggle(a_toggle), .move_tick(a_tick), .pressing(a_press),
        .state_hero(a_hero), .start(a_start), .game_over(a_over), .kill_pulse(a_kill),
        .score(a_score), .state_monsters(a_sm)
    );

    monster_lane_engine #(.MONSTERS(BM), .STEPS(BS), .SPAWN_THRESH(16), .LFSR_SEED(16'hACE1)) dut_b (
        .clk_game(clk), .rst_n(rst_n), .toggle(b_toggle), .move_tick(b_tick), .pressing(b_press),
        .state_hero(b_hero), .start(b_start), .game_over(b_over), .kill_pulse(b_kill),
        .score(b_score), .state_monsters(b_sm)
    );

    // Reference LFSR: x^16+x^14+x^13+x^11 Galois form, running every cycle out of reset
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    int sel;
    int n_mon, n_steps, n_thresh, rec_w;
    bit m_alive [32];
    int m_step  [32];
    int m_lane  [32];
    int m_score, m_phase, m_dir;
    bit m_latch, m_kill, m_press_q;
    logic [15:0] last_lf;
    int n_checks, n_fail;

    logic [511:0] o_rec;
    logic         o_start, o_over, o_kill;
    logic [15:0]  o_score;
    always_comb begin
        if (sel == 0) begin
            o_rec = 512'(a_sm); o_start = a_start; o_over = a_over; o_kill = a_kill; o_score = a_score;
        end else begin
            o_rec = 512'(b_sm); o_start = b_start; o_over = b_over; o_kill = b_kill; o_score = b_score;
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] exp_rec();
        logic [511:0] v;
        logic [511:0] r;
        v = '0;
        for (int i = 0; i < n_mon; i++) begin
            r = 512'((m_step[i] << 3) | (m_lane[i] << 1) | int'(m_alive[i]));
            v = v | (r << (i * rec_w));
        end
        return v;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ":start"}, 512'(o_start), 512'(m_phase == 1));
        chk({tag, ":game_over"}, 512'(o_over), 512'(m_phase == 2));
        chk({tag, ":kill_pulse"}, 512'(o_kill), 512'(m_kill));
        chk({tag, ":score"}, 512'(o_score), 512'(m_score));
        chk({tag, ":records"}, o_rec, exp_rec());
    endtask

    task automatic clear_recs();
        for (int i = 0; i < 32; i++) begin
            m_alive[i] = 1'b0; m_step[i] = 0; m_lane[i] = 0;
        end
    endtask

    task automatic tick_model(input logic [15:0] lf);
        int fr;
        bit miss, killed;
        fr = -1; miss = 0; killed = 0;
        for (int i = 0; i < n_mon; i++) if (!m_alive[i] && fr < 0) fr = i;
        for (int i = 0; i < n_mon; i++) begin
            if (m_alive[i]) begin
                if (m_step[i] < n_steps - 1) m_step[i]++;
                else if (m_latch && m_dir == (m_lane[i] ^ 1)) begin
                    m_alive[i] = 0; m_step[i] = 0; m_lane[i] = 0; killed = 1;
                end else miss = 1;
            end
        end
        if (int'(lf[3:0]) < n_thresh && fr >= 0) begin
            m_alive[fr] = 1; m_step[fr] = 0; m_lane[fr] = int'(lf[5:4]);
        end
        if (killed) begin
            m_kill = 1;
            if (m_score < 65535) m_score++;
        end
        if (miss) m_phase = 2;
        m_latch = 0;
    endtask

    // Drive one cycle from a negedge, model the intervening posedge, check at the next negedge
    task automatic apply(input logic tg, input logic tk, input logic pr, input logic [1:0] hero,
                         input string tag);
        logic [15:0] lf;
        bit redge;
        lf = m_lfsr;
        last_lf = lf;
        if (sel == 0) begin a_toggle = tg; a_tick = tk; a_press = pr; a_hero = hero; end
        else          begin b_toggle = tg; b_tick = tk; b_press = pr; b_hero = hero; end
        @(negedge clk);
        if (sel == 0) a_tick = 1'b0; else b_tick = 1'b0;
        redge = pr && !m_press_q;
        m_press_q = pr;
        m_kill = 0;
        case (m_phase)
            0: if (tg) begin m_phase = 1; m_score = 0; end
            1: begin
                if (!tg) begin m_phase = 0; clear_recs(); end
                else if (tk) tick_model(lf);
            end
            default: if (!tg) begin m_phase = 0; clear_recs(); end
        endcase
        if (redge) begin m_latch = 1; m_dir = int'(hero); end
        check_all(tag);
    endtask

    task automatic press(input logic [1:0] d, input string tag);
        apply(1'b1, 1'b0, 1'b1, d, tag);
        apply(1'b1, 1'b0, 1'b0, d, tag);
    endtask

    function automatic int strike_idx();
        for (int i = 0; i < n_mon; i++) if (m_alive[i] && m_step[i] == n_steps - 1) return i;
        return -1;
    endfunction

    // Play n ticks killing every striker; with lose set, deliberately miss a lane-2 striker
    task automatic play(input int n, input bit lose, input string tag);
        int s;
        bit done;
        done = 0;
        for (int t = 0; t < n && !done; t++) begin
            repeat ($urandom_range(0, 2)) apply(1'b1, 1'b0, 1'b0, 2'($urandom), tag);
            s = strike_idx();
            if (s >= 0) begin
                if (lose && (m_lane[s] == 2 || t >= n - 2)) begin
                    press(2'(m_lane[s]), {tag, "_miss"});
                    done = 1;
                end else begin
                    if ($urandom_range(0, 1) == 1) press(2'(m_lane[s]), tag);
                    press(2'(m_lane[s] ^ 1), tag);
                end
            end
            apply(1'b1, 1'b1, 1'b0, 2'b00, {tag, "_tick"});
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; sel = 0;
        n_mon = AM; n_steps = AS; n_thresh = 16; rec_w = AR;
        m_score = 0; m_phase = 0; m_dir = 0; m_latch = 0; m_kill = 0; m_press_q = 0;
        clear_recs();
        rst_n = 1'b0;
        a_toggle = 1'b1; a_tick = 1'b0; a_press = 1'b0; a_hero = 2'b00;
        b_toggle = 1'b0; b_tick = 1'b0; b_press = 1'b0; b_hero = 2'b00;
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("reset_b:records", 512'(b_sm), 512'(0));
        rst_n = 1'b1;
        apply(1'b1, 1'b0, 1'b0, 2'b00, "restart");

        // First tick spawns into slot 0 with the lane taken from the LFSR
        apply(1'b1, 1'b1, 1'b0, 2'b00, "spawn1");
        chk("spawn1:slot0_alive", 512'(a_sm[0]), 512'(1));
        chk("spawn1:slot0_lane", 512'(a_sm[2:1]), 512'(last_lf[5:4]));

        play(25, 1'b0, "kills");
        play(40, 1'b1, "lose");
        repeat (3) apply(1'b1, 1'b1, 1'b0, 2'b00, "frozen");
        chk("lose:phase_over", 512'(m_phase), 512'(2));

        apply(1'b0, 1'b0, 1'b0, 2'b00, "to_idle");
        apply(1'b0, 1'b1, 1'b0, 2'b00, "idle_tick");
        apply(1'b1, 1'b0, 1'b0, 2'b00, "rerun");
        play(8, 1'b0, "rerun");
        apply(1'b0, 1'b1, 1'b0, 2'b00, "drop_with_tick");
        apply(1'b1, 1'b0, 1'b0, 2'b00, "restart_clear");

        // Two-slot, sixteen-step configuration
        sel = 1; n_mon = BM; n_steps = BS; n_thresh = 16; rec_w = BR;
        m_score = 0; m_phase = 0; m_latch = 0; m_kill = 0; m_press_q = 0;
        clear_recs();
        apply(1'b1, 1'b0, 1'b0, 2'b00, "b_run");
        repeat (3) apply(1'b1, 1'b1, 1'b0, 2'b00, "b_fill");
        chk("b_fill:both_alive", 512'({b_sm[BR], b_sm[0]}), 512'(3));
        play(7, 1'b0, "b_pre");
        force dut_b.r_score = 16'hFFFF;
        @(negedge clk);
        release dut_b.r_score;
        m_score = 65535; m_kill = 0; m_press_q = 0;
        check_all("b_forced");
        play(15, 1'b0, "b_sat");
        chk("b_sat:score", 512'(b_score), 512'(16'hFFFF));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
